// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - parametrised shift-add multiplier, unsigned or two's-complement
// Multiplies operand magnitudes over WIDTH busy cycles, sign-corrects before registering the product.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic               i_signed,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  input  logic               i_abort,
  output logic               o_busy,
  output logic               o_finished,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q;
  logic [2*WIDTH-1:0] mcand_sh_q;
  logic [WIDTH-1:0]   mplier_q;
  logic               neg_q;
  logic [CW-1:0]      count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] product_q;
  logic               busy_q;
  logic               finished_q;

  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] product_d;
  logic               last_step;

  // The magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  always_comb begin
    acc_d     = acc_q + (mplier_q[0] ? mcand_sh_q : '0);
    product_d = neg_q ? -acc_d : acc_d;
    last_step = (count_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= IDLE;
      mcand_sh_q <= '0;
      mplier_q   <= '0;
      neg_q      <= 1'b0;
      count_q    <= '0;
      acc_q      <= '0;
      product_q  <= '0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (i_start) begin
            mcand_sh_q <= {{WIDTH{1'b0}}, magnitude(i_multiplicand, i_signed)};
            mplier_q   <= magnitude(i_multiplier, i_signed);
            neg_q      <= i_signed & (i_multiplicand[WIDTH-1] ^ i_multiplier[WIDTH-1]);
            count_q    <= '0;
            acc_q      <= '0;
            state_q    <= BUSY;
            busy_q     <= 1'b1;
            finished_q <= 1'b0;
          end
        end
        BUSY: begin
          if (i_abort) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
          end else begin
            acc_q      <= acc_d;
            mcand_sh_q <= mcand_sh_q << 1;
            mplier_q   <= mplier_q >> 1;
            count_q    <= count_q + CW'(1);
            if (last_step) begin
              product_q  <= product_d;
              state_q    <= DONE;
              busy_q     <= 1'b0;
              finished_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          busy_q     <= 1'b0;
          finished_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_finished = finished_q;
  assign o_product  = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - directed vectors for seq_multiplier at WIDTH 4 and 8
// Table-driven operations plus hand sequences for overload, abort and asynchronous reset.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sgn;
  logic        start4, abort4, start8, abort8;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic        busy4, fin4, busy8, fin8;
  logic [7:0]  prod4;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(4)) dut4 (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start4), .i_signed(sgn),
    .i_multiplicand(a4), .i_multiplier(b4), .i_abort(abort4),
    .o_busy(busy4), .o_finished(fin4), .o_product(prod4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start8), .i_signed(sgn),
    .i_multiplicand(a8), .i_multiplier(b8), .i_abort(abort8),
    .o_busy(busy8), .o_finished(fin8), .o_product(prod8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs4(input string name, input logic busy, input logic fin, input logic [7:0] prod);
    check({name, ".busy"}, {15'd0, busy4}, {15'd0, busy});
    check({name, ".finished"}, {15'd0, fin4}, {15'd0, fin});
    check({name, ".product"}, {8'd0, prod4}, {8'd0, prod});
  endtask

  // One full operation on the selected instance: latency, busy profile and product.
  task automatic do_op(input bit w8, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp, input string name);
    int  lat;
    int  width;
    bit  busy_ok;
    logic cb, cf;
    logic [15:0] cp;
    width = w8 ? 8 : 4;
    @(negedge clk);
    sgn = s;
    if (w8) begin a8 = a; b8 = b; start8 = 1'b1; end
    else begin a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1; end
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    cf = w8 ? fin8 : fin4;
    while (!cf && lat < 3 * width) begin
      cb = w8 ? busy8 : busy4;
      if (cb !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
      cf = w8 ? fin8 : fin4;
    end
    cb = w8 ? busy8 : busy4;
    cp = w8 ? prod8 : {8'd0, prod4};
    check({name, ".latency"}, 16'(lat), 16'(width));
    check({name, ".busy_during"}, {15'd0, busy_ok}, 16'd1);
    check({name, ".busy_at_done"}, {15'd0, cb}, 16'd0);
    check({name, ".product"}, cp, exp);
  endtask

  vec_t vecs[$];

  initial begin
    logic signed [7:0]  sa, sb;
    logic signed [15:0] sp;
    logic [7:0]         ua, ub;

    vecs.push_back('{4'hF, 4'hF, 1'b0, 8'hE1});
    vecs.push_back('{4'h8, 4'h8, 1'b1, 8'h40});
    vecs.push_back('{4'h8, 4'h7, 1'b1, 8'hC8});
    vecs.push_back('{4'h8, 4'h7, 1'b0, 8'h38});
    vecs.push_back('{4'h0, 4'hD, 1'b0, 8'h00});
    vecs.push_back('{4'h7, 4'hF, 1'b1, 8'hF9});
    vecs.push_back('{4'hF, 4'hF, 1'b1, 8'h01});
    vecs.push_back('{4'h5, 4'hD, 1'b1, 8'hF1});
    vecs.push_back('{4'hD, 4'hD, 1'b0, 8'hA9});
    vecs.push_back('{4'hE, 4'h3, 1'b1, 8'hFA});
    vecs.push_back('{4'h1, 4'h1, 1'b0, 8'h01});

    rst_n = 1'b0; sgn = 1'b0;
    start4 = 1'b0; abort4 = 1'b0; start8 = 1'b0; abort8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check_outs4("reset", 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op(1'b0, {4'd0, vecs[i].a}, {4'd0, vecs[i].b}, vecs[i].s, {8'd0, vecs[i].exp},
            $sformatf("w4_vec%0d", i));

    // Start held through BUSY: second operands ignored until the DONE edge.
    @(negedge clk);
    sgn = 1'b0; a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd6;
    check_outs4("ovl_e0", 1'b1, 1'b0, 8'h01);
    repeat (3) @(negedge clk);
    check_outs4("ovl_e3", 1'b1, 1'b0, 8'h01);
    @(negedge clk);
    check_outs4("ovl_e4", 1'b0, 1'b1, 8'd15);
    @(negedge clk);
    check_outs4("ovl_e5", 1'b1, 1'b0, 8'd15);
    repeat (3) @(negedge clk);
    check_outs4("ovl_e8", 1'b1, 1'b0, 8'd15);
    @(negedge clk);
    start4 = 1'b0;
    check_outs4("ovl_e9", 1'b0, 1'b1, 8'd42);

    // Abort sampled mid-operation returns to IDLE with the old product.
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd9; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    check_outs4("abort", 1'b0, 1'b0, 8'd42);
    @(negedge clk);
    check_outs4("abort_idle", 1'b0, 1'b0, 8'd42);
    do_op(1'b0, 8'd2, 8'd2, 1'b0, 16'd4, "after_abort");
    abort4 = 1'b1;
    @(negedge clk);
    abort4 = 1'b0;
    check_outs4("abort_in_done", 1'b0, 1'b1, 8'd4);

    // Asynchronous reset between E1 and E2, start already present on the release edge.
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd9; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_outs4("async_reset", 1'b0, 1'b0, 8'h00);
    a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
    @(negedge clk);
    check_outs4("reset_held", 1'b0, 1'b0, 8'h00);
    #1 rst_n = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check_outs4("release_start", 1'b1, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check_outs4("release_e3", 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    check_outs4("release_e4", 1'b0, 1'b1, 8'h01);

    do_op(1'b1, 8'h80, 8'h80, 1'b1, 16'h4000, "w8_minmin");
    do_op(1'b1, 8'hFF, 8'hFF, 1'b0, 16'hFE01, "w8_maxu");
    do_op(1'b1, 8'h80, 8'h7F, 1'b1, 16'hC080, "w8_minmax");
    for (int i = 0; i < 40; i++) begin
      ua = 8'($urandom_range(0, 255));
      ub = 8'($urandom_range(0, 255));
      sa = ua; sb = ub;
      sp = sa * sb;
      do_op(1'b1, ua, ub, i[0], i[0] ? sp : 16'(ua) * 16'(ub), $sformatf("w8_rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  always @(negedge clk) begin
    if ((busy4 && fin4) || (busy8 && fin8)) begin
      errors++;
      $display("FAIL busy_and_finished: busy4=%0b fin4=%0b busy8=%0b fin8=%0b required not both", busy4, fin4, busy8, fin8);
    end
  end

endmodule
